// File: rtl/ctrl_defs.sv
// Shared control encodings for the decode/execute boundary: opcodes, ALUOp codes,
// MUL detection constants, the multiply-hold FSM states and the ID/EX control bundle.
package ctrl_defs;

    localparam logic [6:0] OP_ALU_R     = 7'b0110011;
    localparam logic [6:0] OP_ALU_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH_EQ = 7'b1100011;
    localparam logic [6:0] OP_JUMP      = 7'b1101111;

    localparam logic [6:0] FUNCT7_MUL   = 7'b0000001;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_SUB    = 2'b01,
        ALUOP_R_TYPE = 2'b10
    } alu_op_e;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    reg_dst;
        logic    branch;
        logic    mem_read;
        logic    mem_2_reg;
        logic    mem_write;
        logic    alu_src;
        logic    reg_write;
        logic    jump;
        logic    is_mul;
    } ctrl_t;

endpackage

// File: rtl/mul_hold_fsm.sv
// Tracks how long a MUL has sat in EX and asserts mul_hold until its final cycle.
// The first EX cycle is covered combinationally from ex_is_mul; the counter covers the rest.
module mul_hold_fsm
    import ctrl_defs::*;
#(
    parameter int MUL_LATENCY = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic ex_is_mul,
    output logic mul_hold
);

    localparam int CNT_W = $clog2(MUL_LATENCY);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LATENCY - 2);

    mul_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (ex_is_mul) begin
                        state_q <= MUL_BUSY;
                        cnt_q   <= CNT_INIT;
                    end
                end
                MUL_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= MUL_IDLE;
                    end
                end
                default: begin
                    state_q <= MUL_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Released on the last EX cycle so the result is consumed while ID/EX reloads.
    assign mul_hold = ((state_q == MUL_IDLE) && ex_is_mul) ||
                      ((state_q == MUL_BUSY) && (cnt_q != '0));

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control register with load-use bubble insertion, multi-cycle MUL hold and
// flush squash; drives the front-end enables and the EX/MEM bubble request.
module id_ex_ctrl_stage
    import ctrl_defs::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_reg_dst,
    input  logic                  id_branch,
    input  logic                  id_mem_read,
    input  logic                  id_mem_2_reg,
    input  logic                  id_mem_write,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic                  id_jump,
    input  logic                  id_is_mul,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_reg_dst,
    output logic                  ex_branch,
    output logic                  ex_mem_read,
    output logic                  ex_mem_2_reg,
    output logic                  ex_mem_write,
    output logic                  ex_alu_src,
    output logic                  ex_reg_write,
    output logic                  ex_jump,
    output logic                  ex_is_mul,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  mul_hold,
    output logic                  ex_mem_bubble
);

    ctrl_t                 id_ctrl;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  luse;
    logic                  stall;

    assign id_ctrl = '{
        alu_op:    alu_op_e'(id_alu_op),
        reg_dst:   id_reg_dst,
        branch:    id_branch,
        mem_read:  id_mem_read,
        mem_2_reg: id_mem_2_reg,
        mem_write: id_mem_write,
        alu_src:   id_alu_src,
        reg_write: id_reg_write,
        jump:      id_jump,
        is_mul:    id_is_mul
    };

    mul_hold_fsm #(
        .MUL_LATENCY(MUL_LATENCY)
    ) u_mul_hold_fsm (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .ex_is_mul(ctrl_q.is_mul),
        .mul_hold (mul_hold)
    );

    // rs2 is compared even for I-types; the occasional extra stall is harmless.
    assign luse  = ctrl_q.mem_read && (rd_q != '0) &&
                   ((rd_q == id_rs1) || (rd_q == id_rs2));
    assign stall = mul_hold || luse;

    always_comb begin
        ctrl_d = ctrl_q;
        rd_d   = rd_q;
        if (flush) begin
            ctrl_d = '0;
            rd_d   = '0;
        end else if (mul_hold) begin
            ctrl_d = ctrl_q;
            rd_d   = rd_q;
        end else if (luse) begin
            ctrl_d = '0;
            rd_d   = '0;
        end else begin
            ctrl_d = id_ctrl;
            rd_d   = id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd_q   <= rd_d;
        end
    end

    // A redirect must reach the PC even while the pipe is stalled.
    assign pc_write      = flush || !stall;
    assign if_id_write   = !flush && !stall;
    assign ex_mem_bubble = mul_hold && !flush;

    assign ex_alu_op    = ctrl_q.alu_op;
    assign ex_reg_dst   = ctrl_q.reg_dst;
    assign ex_branch    = ctrl_q.branch;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_2_reg = ctrl_q.mem_2_reg;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_alu_src   = ctrl_q.alu_src;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_jump      = ctrl_q.jump;
    assign ex_is_mul    = ctrl_q.is_mul;
    assign ex_rd        = rd_q;

endmodule
